// File: rtl/bht_port_scheduler_pkg.sv
// rtl/bht_port_scheduler_pkg.sv - shared constants and FSM encoding for the BHT port scheduler
// Purpose: default parameter values and scheduler state encoding.
// Ports:   none (package).
package bht_port_scheduler_pkg;

   localparam int DEF_PC_W       = 4;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_AGE_MAX    = 8;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } sched_state_t;

endpackage

// File: rtl/bht_port_scheduler_if.sv
// rtl/bht_port_scheduler_if.sv - fetch/execute/table signal bundle for the BHT port scheduler
// Purpose: groups the lookup, update and table-port signals.
// Ports:   master = fetch/execute/table side, slave = scheduler side.
//          lookup_req/pc -> lookup_stall/valid/pred; upd_valid/pc/taken -> upd_ready;
//          tbl_en/taken/pc -> table, tbl_pred <- table.
interface bht_port_scheduler_if
   import bht_port_scheduler_pkg::*;
#(
   parameter int PC_W = DEF_PC_W
);

   logic            lookup_req;
   logic [PC_W-1:0] lookup_pc;
   logic            lookup_stall;
   logic            lookup_valid;
   logic            lookup_pred;

   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;
   logic            upd_ready;

   logic            tbl_en;
   logic            tbl_taken;
   logic [PC_W-1:0] tbl_pc;
   logic            tbl_pred;

   modport master (
      output lookup_req, lookup_pc,
      input  lookup_stall, lookup_valid, lookup_pred,
      output upd_valid, upd_pc, upd_taken,
      input  upd_ready,
      input  tbl_en, tbl_taken, tbl_pc,
      output tbl_pred
   );

   modport slave (
      input  lookup_req, lookup_pc,
      output lookup_stall, lookup_valid, lookup_pred,
      input  upd_valid, upd_pc, upd_taken,
      output upd_ready,
      output tbl_en, tbl_taken, tbl_pc,
      input  tbl_pred
   );

endinterface

// File: rtl/bht_update_fifo.sv
// rtl/bht_update_fifo.sv - synchronous FIFO buffering resolved branch outcomes
// Purpose: stores {pc, taken} entries until the scheduler issues them to the table.
// Ports:   clk, rst (sync, active-high); push/push_data in; pop in;
//          head (oldest entry), count (0..DEPTH), full, empty out.
module bht_update_fifo #(
   parameter int   WIDTH = 5,
   parameter int   DEPTH = 4,
   localparam int  PTR_W = $clog2(DEPTH),
   localparam int  CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A full FIFO refuses a push even when it pops in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // The head is read from storage only, so an empty FIFO never forwards its input.
   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bht_port_scheduler.sv
// rtl/bht_port_scheduler.sv - arbitrates the shared BHT index/update port
// Purpose: grants the single table port to fetch lookups, drains buffered
//          execute updates in idle cycles, and forces a stalled drain when the
//          update FIFO fills or its head waits AGE_MAX cycles.
// Ports:   clk, rst (sync, active-high); bus (slave modport):
//          lookup_req/pc in, lookup_stall (comb), lookup_valid/pred (reg) out;
//          upd_valid/pc/taken in, upd_ready out; tbl_en/taken/pc out, tbl_pred in.
module bht_port_scheduler
   import bht_port_scheduler_pkg::*;
#(
   parameter int PC_W       = DEF_PC_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AGE_MAX    = DEF_AGE_MAX
) (
   input  logic                  clk,
   input  logic                  rst,
   bht_port_scheduler_if.slave   bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int AGE_W = $clog2(AGE_MAX + 1);

   sched_state_t     state;
   sched_state_t     state_next;

   logic [PC_W:0]    head;
   logic [PC_W-1:0]  head_pc;
   logic             head_taken;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             grant;
   logic             force_cond;
   logic [AGE_W-1:0] age;

   assign push          = bus.upd_valid && !full;
   assign bus.upd_ready = !full;
   assign head_pc       = head[PC_W:1];
   assign head_taken    = head[0];

   bht_update_fifo #(
      .WIDTH (PC_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({bus.upd_pc, bus.upd_taken}),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Judged on registered count/age; the state change lands next cycle.
   assign force_cond = full || ((age == AGE_W'(AGE_MAX)) && !empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_NORMAL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      pop              = 1'b0;
      grant            = 1'b0;
      bus.tbl_en       = 1'b0;
      bus.tbl_taken    = 1'b0;
      bus.tbl_pc       = '0;
      bus.lookup_stall = 1'b0;

      // While reset is asserted the port stays quiet so queued updates never
      // reach the table and no lookup is granted.
      if (!rst) begin
         if (state == ST_FORCE) begin
            bus.lookup_stall = bus.lookup_req;
            pop              = !empty;
         end else if (bus.lookup_req) begin
            grant      = 1'b1;
            bus.tbl_pc = bus.lookup_pc;
         end else begin
            pop = !empty;
         end
      end

      if (pop) begin
         bus.tbl_en    = 1'b1;
         bus.tbl_pc    = head_pc;
         bus.tbl_taken = head_taken;
      end

      case (state)
         ST_NORMAL: begin
            if (force_cond) begin
               state_next = ST_FORCE;
            end
         end
         ST_FORCE: begin
            // Leave once this cycle's pop empties the FIFO (no refill push).
            if (pop && (count == CNT_W'(1)) && !push) begin
               state_next = ST_NORMAL;
            end
         end
         default: state_next = ST_NORMAL;
      endcase
   end

   // Head age: how long the oldest entry has waited without being issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         age <= '0;
      end else if (pop || empty) begin
         age <= '0;
      end else if (age != AGE_W'(AGE_MAX)) begin
         age <= age + AGE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.lookup_valid <= 1'b0;
         bus.lookup_pred  <= 1'b0;
      end else begin
         bus.lookup_valid <= grant;
         if (grant) begin
            bus.lookup_pred <= bus.tbl_pred;
         end
      end
   end

endmodule

// File: tb/tb_bht_port_scheduler.sv
// tb/tb_bht_port_scheduler.sv - self-checking bench for bht_port_scheduler
module tb_bht_port_scheduler;
   import bht_port_scheduler_pkg::*;

   localparam int PC_W    = 4;
   localparam int DEPTH   = 4;
   localparam int AGE_MAX = 8;

   typedef struct {
      logic [PC_W-1:0] pc;
      logic            taken;
   } upd_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bht_port_scheduler_if #(.PC_W(PC_W)) bus ();

   bht_port_scheduler #(
      .PC_W       (PC_W),
      .FIFO_DEPTH (DEPTH),
      .AGE_MAX    (AGE_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural history table seen by the DUT: last outcome per index.
   logic tbl_mem [16] = '{default: 1'b0};
   assign bus.tbl_pred = tbl_mem[bus.tbl_pc];
   always @(posedge clk) begin
      if (bus.tbl_en) tbl_mem[bus.tbl_pc] <= bus.tbl_taken;
   end

   // Reference model state.
   upd_t q[$];
   bit   m_force;
   int   m_age;
   bit   m_lv;
   bit   m_lp;
   bit   ref_tbl [16];

   int   n_checks;
   int   n_pass;
   int   stall_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic drive(input bit req, input logic [PC_W-1:0] pc,
                        input bit uv, input logic [PC_W-1:0] upc, input bit ut);
      bus.lookup_req = req;
      bus.lookup_pc  = pc;
      bus.upd_valid  = uv;
      bus.upd_pc     = upc;
      bus.upd_taken  = ut;
      #2;
   endtask

   // Compare one cycle's outputs with the model, then advance both.
   task automatic cycle();
      bit              issue, grant, stall, push;
      logic [PC_W-1:0] epc;
      bit              etaken;
      int              cnt;
      cnt = q.size();
      issue = 0; grant = 0; stall = 0; epc = '0; etaken = 0;
      if (!rst) begin
         if (m_force) begin
            issue = (cnt > 0);
            stall = bus.lookup_req;
         end else if (bus.lookup_req) begin
            grant = 1;
         end else begin
            issue = (cnt > 0);
         end
      end
      if (issue) begin
         epc    = q[0].pc;
         etaken = q[0].taken;
      end else if (grant) begin
         epc = bus.lookup_pc;
      end
      chk("upd_ready",    32'(bus.upd_ready),    32'(cnt < DEPTH));
      chk("tbl_en",       32'(bus.tbl_en),       32'(issue));
      chk("tbl_pc",       32'(bus.tbl_pc),       32'(epc));
      chk("tbl_taken",    32'(bus.tbl_taken),    32'(etaken));
      chk("lookup_stall", 32'(bus.lookup_stall), 32'(stall));
      chk("lookup_valid", 32'(bus.lookup_valid), 32'(m_lv));
      chk("lookup_pred",  32'(bus.lookup_pred),  32'(m_lp));
      if (stall) stall_cnt++;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_force = 0; m_age = 0; m_lv = 0; m_lp = 0;
      end else begin
         push = bus.upd_valid && (cnt < DEPTH);
         if (!m_force) m_force = (cnt == DEPTH) || (m_age == AGE_MAX && cnt > 0);
         else if (cnt - int'(issue) + int'(push) == 0) m_force = 0;
         if (issue || cnt == 0) m_age = 0;
         else if (m_age < AGE_MAX) m_age++;
         m_lv = grant;
         if (grant) m_lp = ref_tbl[bus.lookup_pc];
         if (issue) begin
            ref_tbl[q[0].pc] = q[0].taken;
            void'(q.pop_front());
         end
         if (push) q.push_back('{bus.upd_pc, bus.upd_taken});
      end
      #1;
   endtask

   initial begin
      n_checks = 0; n_pass = 0; stall_cnt = 0;
      m_force = 0; m_age = 0; m_lv = 0; m_lp = 0;
      foreach (ref_tbl[i]) ref_tbl[i] = 0;
      rst = 1'b1;
      bus.lookup_req = 0; bus.lookup_pc = '0;
      bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values, idle.
      drive(0, 0, 0, 0, 0);
      chk("rst_upd_ready",    32'(bus.upd_ready), 32'(1));
      chk("rst_tbl_en",       32'(bus.tbl_en), 32'(0));
      chk("rst_tbl_pc",       32'(bus.tbl_pc), 32'(0));
      chk("rst_lookup_valid", 32'(bus.lookup_valid), 32'(0));
      chk("rst_lookup_pred",  32'(bus.lookup_pred), 32'(0));
      cycle(); cycle();

      // Single update drains one cycle after push.
      drive(0, 0, 1, 5, 1);
      cycle();
      drive(0, 0, 0, 0, 0);
      chk("upd5_en",    32'(bus.tbl_en), 32'(1));
      chk("upd5_pc",    32'(bus.tbl_pc), 32'(5));
      chk("upd5_taken", 32'(bus.tbl_taken), 32'(1));
      cycle();
      chk("upd5_drained", 32'(bus.tbl_en), 32'(0));
      cycle();

      // Fill under continuous lookups: forced drain of 4 stalled cycles.
      stall_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, PC_W'(i), 1, PC_W'(10 + i), i[0]);
         cycle();
      end
      for (int i = 0; i < 12; i++) begin
         drive(1, PC_W'(i), 0, 0, 0);
         cycle();
      end
      chk("full_stalls", 32'(stall_cnt), 32'(4));
      chk("full_lookup_back", 32'(bus.lookup_valid), 32'(1));

      // Single update under continuous lookups: age-forced drain, one stall.
      stall_cnt = 0;
      drive(1, 2, 1, 7, 0);
      cycle();
      for (int i = 0; i < 14; i++) begin
         drive(1, 2, 0, 0, 0);
         cycle();
      end
      chk("age_stalls", 32'(stall_cnt), 32'(1));

      // Train pc 3 taken, then look it up.
      drive(0, 0, 1, 3, 1);
      cycle();
      drive(0, 0, 0, 0, 0);
      cycle(); cycle();
      drive(1, 3, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0);
      chk("train_valid", 32'(bus.lookup_valid), 32'(1));
      chk("train_pred",  32'(bus.lookup_pred), 32'(1));
      cycle();

      // Reset with 3 queued updates: they never reach the table.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, PC_W'(12 + i), 1);
         cycle();
      end
      rst = 1'b1;
      drive(1, 0, 0, 0, 0);
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 0, 0);
         chk("post_rst_tbl_en", 32'(bus.tbl_en), 32'(0));
         chk("post_rst_ready",  32'(bus.upd_ready), 32'(1));
         cycle();
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive(($urandom_range(0, 9) < 7), PC_W'($urandom),
               ($urandom_range(0, 1) == 1), PC_W'($urandom), 1'($urandom));
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
